// File: rtl/aurora_in_fifo.sv
// Input staging FIFO ahead of the Aurora processor: valid/ready producer side,
// strobe-pop consumer side with a combinational head and a threshold interrupt.
module aurora_in_fifo #(
    parameter int NUBITS = 32,
    parameter int DEPTH  = 16,
    parameter int THRESH = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic signed [NUBITS-1:0]   s_data,
    input  logic                       s_valid,
    output logic                       s_ready,
    input  logic                       req_in,
    output logic signed [NUBITS-1:0]   io_in,
    output logic                       itr,
    output logic [$clog2(DEPTH):0]     level,
    output logic                       ovf,
    output logic                       udf,
    input  logic                       clr_flags
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam logic [LW-1:0] L_DEPTH  = LW'(DEPTH);
    localparam logic [LW-1:0] L_THRESH = LW'(THRESH);

    logic [NUBITS-1:0] r_mem [DEPTH];
    logic [AW-1:0]     r_wp;
    logic [AW-1:0]     r_rp;
    logic [LW-1:0]     r_level;
    logic              r_itr;
    logic              r_ovf;
    logic              r_udf;

    logic              w_full;
    logic              w_empty;
    logic              w_push;
    logic              w_pop;
    logic [LW-1:0]     w_level_next;

    // Occupancy is tracked separately from the pointers, so full and empty never alias.
    assign w_full  = (r_level == L_DEPTH);
    assign w_empty = (r_level == '0);
    assign w_push  = s_valid && !w_full;
    assign w_pop   = req_in && !w_empty;

    // NOTE: every output of a combinational block gets a default first, so no
    // path through it leaves a value held and no latch is inferred.
    always_comb begin
        w_level_next = r_level;
        unique case ({w_push, w_pop})
            2'b10:   w_level_next = r_level + LW'(1);
            2'b01:   w_level_next = r_level - LW'(1);
            default: w_level_next = r_level;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wp    <= '0;
            r_rp    <= '0;
            r_level <= '0;
            r_itr   <= 1'b0;
            r_ovf   <= 1'b0;
            r_udf   <= 1'b0;
        end else begin
            if (w_push) r_wp <= r_wp + AW'(1);
            if (w_pop)  r_rp <= r_rp + AW'(1);
            r_level <= w_level_next;
            r_itr   <= (w_level_next >= L_THRESH) && (r_level < L_THRESH);
            // A flag event in the same cycle as clr_flags keeps the flag set.
            r_ovf   <= (s_valid && w_full)  || (r_ovf && !clr_flags);
            r_udf   <= (req_in  && w_empty) || (r_udf && !clr_flags);
        end
    end

    // NOTE: the storage array has no reset; stale words are unreachable
    // because level and the pointers are reset.
    always_ff @(posedge clk) begin
        if (w_push && !rst) r_mem[r_wp] <= s_data;
    end

    assign s_ready = !w_full;
    assign io_in   = w_empty ? '0 : r_mem[r_rp];
    assign itr     = r_itr;
    assign level   = r_level;
    assign ovf     = r_ovf;
    assign udf     = r_udf;

endmodule

// File: doc/aurora_in_fifo.md
# aurora_in_fifo

Input staging buffer placed directly upstream of the Aurora processor wrapper. It accepts samples from an external producer over a valid/ready handshake and stores them in a circular FIFO. It presents the head word on the processor's `io_in` and pops one word on each processor input request (`req_in`). It also raises a one-cycle `itr` pulse when the buffered level reaches a programmable threshold, so the processor's interrupt routine can drain the batch.

## Interface
Parameters:
- NUBITS, 32, sample width; matches the processor data width.
- DEPTH, 16, FIFO entries; power of two, 2..256.
- THRESH, 8, fill level that triggers `itr`; 1..DEPTH.

Ports:
- clk  in  1  single clock; all logic on rising edge.
- rst  in  1  reset, synchronous, active-high.
- s_data  in  NUBITS  producer sample (signed).
- s_valid  in  1  producer has a sample.
- s_ready  out  1  FIFO can accept; equals !full.
- req_in  in  1  processor input strobe; pops head at this edge.
- io_in  out  NUBITS  head sample to processor (signed); 0 when empty.
- itr  out  1  interrupt pulse to processor.
- level  out  clog2(DEPTH)+1  current occupancy, 0..DEPTH.
- ovf  out  1  sticky: producer presented s_valid while full.
- udf  out  1  sticky: req_in while empty.
- clr_flags  in  1  clears ovf/udf.

## Operation
- Storage: DEPTH x NUBITS register array; write pointer wp and read pointer rp, each clog2(DEPTH) bits, wrap modulo DEPTH. Occupancy counter `level` is held separately, so full and empty are unambiguous.
- full = (level == DEPTH); empty = (level == 0).
- push = s_valid && s_ready; the word is written at mem[wp] and wp increments.
- pop = req_in && !empty; rp increments. The head is not cleared.
- `level` update: +1 on push only, -1 on pop only, unchanged on both or neither.
- Simultaneous push and pop when not empty and not full: both happen and level is unchanged.
- Push and req_in while empty: push is accepted, pop is ignored, and udf is set.
- When full, s_ready is 0, so no push can occur even if a pop happens in the same cycle. There is no pass-through.
- io_in is combinational: mem[rp] when !empty, else 0.
- itr is a registered edge detect: itr <= (level_next >= THRESH) && (level < THRESH). It is one cycle wide and fires again only after level drops below THRESH and re-crosses it.
- ovf is set when s_valid && full. udf is set when req_in && empty.
- Priority on the flags: a set in the same cycle as clr_flags wins over the clear.
- The memory array is not reset. All control state is reset.

## Timing
- Reset values: s_ready=1, io_in=0, itr=0, level=0, ovf=0, udf=0, wp=rp=0.
- Reset asserted mid-operation discards all contents at that edge. Data, handshakes and req_in presented in that cycle are ignored.
- Push latency: a word accepted at edge N is visible on io_in after edge N (combinational head) if the FIFO was empty. level reflects it after edge N.
- Pop: the processor samples io_in in the cycle it asserts req_in. The next word appears after that edge.
- itr goes high in the cycle right after the edge at which level first reaches THRESH, coincident with the updated level.
- s_ready deasserts in the cycle after the push that makes level == DEPTH. It reasserts in the cycle after the first pop.
- Pointer wrap: DEPTH-1 -> 0 with no bubble.

## Test plan
- Reset then idle: after rst high for 2 cycles, s_ready=1, level=0, io_in=0, itr=0, ovf=udf=0.
- Fill to threshold: push 1..8 on consecutive cycles, no req_in -> level counts 1..8, itr=1 for exactly one cycle after the 8th push, io_in=1 throughout.
- Fill/overflow/drain (DEPTH=16): push 16 words -> s_ready=0. Hold s_valid one more cycle -> ovf=1, level stays 16. Pulse req_in 16 times -> io_in sequence 1..16, then io_in=0, level=0.
- Simultaneous push/pop at level 5: 10 cycles with s_valid and req_in both high -> level stays 5, FIFO order preserved, rp and wp wrap without loss.
- Underflow on empty with push: level=0, s_valid=1 (data 0x7FFFFFFF) and req_in=1 in the same cycle -> level=1, io_in=0x7FFFFFFF, udf=1. Then clr_flags -> udf=0.
- Reset mid-stream at level 10 with push active -> next cycle level=0, io_in=0, itr=0, and the pushed word is not stored.
